// File: rtl/commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : commit_stage
// Purpose  : Retire stage downstream of the ROB. Accepts the ROB head, writes
//            the register file one cycle later, queues committed stores in a
//            small FIFO store buffer that drains to data memory over req/gnt,
//            raises a one-cycle flush with redirect PC on a taken branch and
//            counts retired instructions.
// Ports    : clk_i/rstn_i            clock, async active-low reset
//            commit_*_i / _ready_o   ROB head handshake (pop on valid&ready)
//            rf_*_o                  registered regfile write port
//            flush_o/redirect_pc_o   front-end redirect, valid for one cycle
//            mem_*_o / mem_gnt_i     store drain port (held until grant)
//            stb_empty_o             store buffer empty
//            instret_o               64-bit retired instruction counter
// Revision : 1.0  initial release
// ============================================================================
module commit_stage #(
  parameter int STB_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        commit_valid_i,
  input  logic [31:0] commit_pc_i,
  input  logic [31:0] commit_instr_i,
  input  logic [4:0]  commit_rd_addr_i,
  input  logic [31:0] commit_result_i,
  input  logic [31:0] commit_store_data_i,
  input  logic        commit_write_enable_i,
  input  logic        commit_store_to_mem_i,
  input  logic [31:0] commit_new_pc_i,
  input  logic        commit_branch_taken_i,
  output logic        commit_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_addr_o,
  output logic [31:0] rf_data_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  output logic        stb_empty_o,
  output logic [63:0] instret_o
);

  localparam int PTR_W = $clog2(STB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    DRAIN_IDLE = 1'b0,
    DRAIN_REQ  = 1'b1
  } drain_state_e;

  drain_state_e state_q, state_d;

  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [63:0]      instret_q, instret_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] stb_addr_q [STB_DEPTH];
  logic [31:0] stb_addr_d [STB_DEPTH];
  logic [31:0] stb_data_q [STB_DEPTH];
  logic [31:0] stb_data_d [STB_DEPTH];
  logic [3:0]  stb_be_q   [STB_DEPTH];
  logic [3:0]  stb_be_d   [STB_DEPTH];

  logic        stb_full;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;

  // Full is judged on the registered count only: a same-cycle pop never
  // frees a slot for the incoming store.
  assign stb_full       = (count_q == CNT_W'(STB_DEPTH));
  assign commit_ready_o = !flush_q && !(commit_store_to_mem_i && stb_full);
  assign accept         = commit_valid_i && commit_ready_o;
  assign push           = accept && commit_store_to_mem_i;
  assign pop            = (state_q == DRAIN_REQ) && mem_gnt_i;

  // Lane alignment of the store by funct3; unknown sizes behave as SW.
  always_comb begin
    st_addr = {commit_result_i[31:2], 2'b00};
    st_data = commit_store_data_i;
    st_be   = 4'b1111;
    case (commit_instr_i[14:12])
      3'b000: begin
        st_be   = 4'b0001 << commit_result_i[1:0];
        st_data = {4{commit_store_data_i[7:0]}};
      end
      3'b001: begin
        st_be   = commit_result_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{commit_store_data_i[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = commit_store_data_i;
      end
    endcase
  end

  always_comb begin
    rf_we_d    = accept && commit_write_enable_i && (commit_rd_addr_i != 5'd0);
    rf_addr_d  = rf_we_d ? commit_rd_addr_i : rf_addr_q;
    rf_data_d  = rf_we_d ? commit_result_i  : rf_data_q;
    flush_d    = accept && commit_branch_taken_i;
    redirect_d = flush_d ? commit_new_pc_i : 32'd0;
    instret_d  = instret_q + {63'd0, accept};

    stb_addr_d = stb_addr_q;
    stb_data_d = stb_data_q;
    stb_be_d   = stb_be_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      stb_addr_d[wr_ptr_q] = st_addr;
      stb_data_d[wr_ptr_q] = st_data;
      stb_be_d[wr_ptr_q]   = st_be;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // A store pushed this cycle launches the request next cycle, so the
    // push is folded into the IDLE exit condition.
    state_d = state_q;
    case (state_q)
      DRAIN_IDLE: if ((count_q != '0) || push) state_d = DRAIN_REQ;
      DRAIN_REQ:  if (pop && (count_d == '0))  state_d = DRAIN_IDLE;
      default:    state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= DRAIN_IDLE;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      instret_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      instret_q  <= instret_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    stb_addr_q <= stb_addr_d;
    stb_data_q <= stb_data_d;
    stb_be_q   <= stb_be_d;
  end

  assign rf_we_o       = rf_we_q;
  assign rf_addr_o     = rf_addr_q;
  assign rf_data_o     = rf_data_q;
  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_q;
  assign instret_o     = instret_q;
  assign stb_empty_o   = (count_q == '0);
  assign mem_req_o     = (state_q == DRAIN_REQ);
  // Head entry is only presented while a request is outstanding.
  assign mem_addr_o    = mem_req_o ? stb_addr_q[rd_ptr_q] : 32'd0;
  assign mem_wdata_o   = mem_req_o ? stb_data_q[rd_ptr_q] : 32'd0;
  assign mem_be_o      = mem_req_o ? stb_be_q[rd_ptr_q]   : 4'd0;

  // Diagnostic-only inputs, kept on the port list for trace consumers.
  logic unused_ok;
  assign unused_ok = ^{commit_pc_i, commit_instr_i[31:15], commit_instr_i[11:0]};

endmodule
`default_nettype wire

// File: tb/tb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_stage
// Purpose  : Directed self-checking bench for commit_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_commit_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        commit_valid_i;
  logic [31:0] commit_pc_i;
  logic [31:0] commit_instr_i;
  logic [4:0]  commit_rd_addr_i;
  logic [31:0] commit_result_i;
  logic [31:0] commit_store_data_i;
  logic        commit_write_enable_i;
  logic        commit_store_to_mem_i;
  logic [31:0] commit_new_pc_i;
  logic        commit_branch_taken_i;
  logic        commit_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        stb_empty_o;
  logic [63:0] instret_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  commit_stage #(.STB_DEPTH(4)) dut (
    .clk_i                 (clk_i),
    .rstn_i                (rstn_i),
    .commit_valid_i        (commit_valid_i),
    .commit_pc_i           (commit_pc_i),
    .commit_instr_i        (commit_instr_i),
    .commit_rd_addr_i      (commit_rd_addr_i),
    .commit_result_i       (commit_result_i),
    .commit_store_data_i   (commit_store_data_i),
    .commit_write_enable_i (commit_write_enable_i),
    .commit_store_to_mem_i (commit_store_to_mem_i),
    .commit_new_pc_i       (commit_new_pc_i),
    .commit_branch_taken_i (commit_branch_taken_i),
    .commit_ready_o        (commit_ready_o),
    .rf_we_o               (rf_we_o),
    .rf_addr_o             (rf_addr_o),
    .rf_data_o             (rf_data_o),
    .flush_o               (flush_o),
    .redirect_pc_o         (redirect_pc_o),
    .mem_req_o             (mem_req_o),
    .mem_addr_o            (mem_addr_o),
    .mem_wdata_o           (mem_wdata_o),
    .mem_be_o              (mem_be_o),
    .mem_gnt_i             (mem_gnt_i),
    .stb_empty_o           (stb_empty_o),
    .instret_o             (instret_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_head();
    commit_valid_i        = 1'b0;
    commit_pc_i           = 32'd0;
    commit_instr_i        = 32'd0;
    commit_rd_addr_i      = 5'd0;
    commit_result_i       = 32'd0;
    commit_store_data_i   = 32'd0;
    commit_write_enable_i = 1'b0;
    commit_store_to_mem_i = 1'b0;
    commit_new_pc_i       = 32'd0;
    commit_branch_taken_i = 1'b0;
  endtask

  task automatic store_head(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    idle_head();
    commit_valid_i        = 1'b1;
    commit_instr_i        = {17'd0, f3, 12'h023};
    commit_result_i       = addr;
    commit_store_data_i   = data;
    commit_store_to_mem_i = 1'b1;
  endtask

  initial begin
    idle_head();
    mem_gnt_i = 1'b0;
    rstn_i    = 1'b0;
    tick();
    tick();
    chk("rst_rf_we",     64'(rf_we_o), 64'd0);
    chk("rst_flush",     64'(flush_o), 64'd0);
    chk("rst_mem_req",   64'(mem_req_o), 64'd0);
    chk("rst_stb_empty", 64'(stb_empty_o), 64'd1);
    chk("rst_instret",   instret_o, 64'd0);
    rstn_i = 1'b1;
    tick();

    // ALU retire to x1
    commit_valid_i = 1'b1; commit_rd_addr_i = 5'd1; commit_write_enable_i = 1'b1;
    commit_result_i = 32'hDEADBEEF;
    #1 chk("alu_ready", 64'(commit_ready_o), 64'd1);
    tick();
    idle_head();
    chk("alu_rf_we",   64'(rf_we_o), 64'd1);
    chk("alu_rf_addr", 64'(rf_addr_o), 64'd1);
    chk("alu_rf_data", 64'(rf_data_o), 64'hDEADBEEF);
    chk("alu_instret", instret_o, 64'd1);
    tick();
    chk("alu_rf_we_drop", 64'(rf_we_o), 64'd0);

    // write to x0 is retired but not written
    commit_valid_i = 1'b1; commit_rd_addr_i = 5'd0; commit_write_enable_i = 1'b1;
    commit_result_i = 32'h12345678;
    tick();
    idle_head();
    chk("x0_rf_we",   64'(rf_we_o), 64'd0);
    chk("x0_instret", instret_o, 64'd2);

    // taken branch, then a younger head held during the flush cycle
    commit_valid_i = 1'b1; commit_branch_taken_i = 1'b1; commit_new_pc_i = 32'h40;
    #1 chk("br_ready", 64'(commit_ready_o), 64'd1);
    tick();
    chk("br_flush",    64'(flush_o), 64'd1);
    chk("br_redirect", 64'(redirect_pc_o), 64'h40);
    chk("br_instret",  instret_o, 64'd3);
    idle_head();
    commit_valid_i = 1'b1; commit_rd_addr_i = 5'd2; commit_write_enable_i = 1'b1;
    commit_result_i = 32'h55;
    #1 chk("flush_ready_low", 64'(commit_ready_o), 64'd0);
    tick();
    chk("flush_one_cycle", 64'(flush_o), 64'd0);
    chk("held_not_written", 64'(rf_we_o), 64'd0);
    chk("held_instret", instret_o, 64'd3);
    chk("held_ready", 64'(commit_ready_o), 64'd1);
    tick();
    idle_head();
    chk("held_rf_we",   64'(rf_we_o), 64'd1);
    chk("held_rf_addr", 64'(rf_addr_o), 64'd2);
    chk("held_instret2", instret_o, 64'd4);

    // SB to 0x103 held until granted
    store_head(3'b000, 32'h103, 32'hAB);
    #1 chk("sb_ready", 64'(commit_ready_o), 64'd1);
    tick();
    idle_head();
    chk("sb_req",   64'(mem_req_o), 64'd1);
    chk("sb_addr",  64'(mem_addr_o), 64'h100);
    chk("sb_be",    64'(mem_be_o), 64'b1000);
    chk("sb_wdata", 64'(mem_wdata_o), 64'hABABABAB);
    chk("sb_not_empty", 64'(stb_empty_o), 64'd0);
    tick();
    chk("sb_req_hold2", 64'(mem_req_o), 64'd1);
    tick();
    chk("sb_req_hold3", 64'(mem_req_o), 64'd1);
    chk("sb_addr_hold", 64'(mem_addr_o), 64'h100);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("sb_req_done", 64'(mem_req_o), 64'd0);
    chk("sb_empty",    64'(stb_empty_o), 64'd1);
    chk("sb_instret",  instret_o, 64'd5);

    // fill the buffer with four SW, then stall an SH
    for (int i = 0; i < 4; i++) begin
      store_head(3'b010, 32'h200 + 32'(i * 4) + 32'd3, 32'hC0DE0000 + 32'(i));
      #1 chk("fill_ready", 64'(commit_ready_o), 64'd1);
      tick();
    end
    store_head(3'b001, 32'h303, 32'h1234);
    #1 chk("full_ready", 64'(commit_ready_o), 64'd0);
    tick();
    chk("full_ready_still", 64'(commit_ready_o), 64'd0);
    chk("full_instret", instret_o, 64'd9);
    chk("full_head_addr", 64'(mem_addr_o), 64'h200);
    chk("full_head_be",   64'(mem_be_o), 64'b1111);
    chk("full_head_data", 64'(mem_wdata_o), 64'hC0DE0000);
    mem_gnt_i = 1'b1;
    #1 chk("full_pop_no_free", 64'(commit_ready_o), 64'd0);
    tick();
    mem_gnt_i = 1'b0;
    #1 chk("after_pop_ready", 64'(commit_ready_o), 64'd1);
    chk("after_pop_req",  64'(mem_req_o), 64'd1);
    chk("after_pop_addr", 64'(mem_addr_o), 64'h204);
    tick();
    idle_head();
    chk("sh_instret", instret_o, 64'd10);
    mem_gnt_i = 1'b1;
    tick();
    tick();
    tick();
    mem_gnt_i = 1'b0;
    chk("sh_addr",  64'(mem_addr_o), 64'h300);
    chk("sh_be",    64'(mem_be_o), 64'b1100);
    chk("sh_wdata", 64'(mem_wdata_o), 64'h12341234);
    chk("sh_req",   64'(mem_req_o), 64'd1);

    // asynchronous reset mid-request
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_req",     64'(mem_req_o), 64'd0);
    chk("arst_empty",   64'(stb_empty_o), 64'd1);
    chk("arst_instret", instret_o, 64'd0);
    tick();
    rstn_i = 1'b1;
    tick();
    chk("post_rst_req", 64'(mem_req_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
